// File: rtl/serial_word_collector_pkg.sv
// rtl/serial_word_collector_pkg.sv - shared types and constants for the serial word collector
package serial_pkg;

  localparam int DEFAULT_WIDTH = 5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - serial bit input and word/pulse output bundle
interface serial_word_collector_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             serial_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             load_en;
  logic             frame_err;
  logic             busy;

  modport master (
    output serial_in, bit_valid,
    input  word_out, load_en, frame_err, busy
  );

  modport slave (
    input  serial_in, bit_valid,
    output word_out, load_en, frame_err, busy
  );

endinterface

// File: rtl/serial_word_collector_bit_counter_en.sv
// rtl/serial_word_collector_bit_counter_en.sv - clearable enabled up-counter with terminal-count flag
module bit_counter_en #(
  parameter  int WIDTH = 5,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - assembles LSB-first start/data/stop frames into words
// Optional even-parity bit between data and stop when SERIAL_PARITY_EN is defined.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_word_collector_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   word_q;
  logic               load_q, load_d;
  logic               err_q, err_d;
  logic               cnt_clr, cnt_en, cnt_tc, shift_we;
  logic [CNT_W-1:0]   cnt;
  logic               good_stop;

  bit_counter_en #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

`ifdef SERIAL_PARITY_EN
  logic par_we, par_err_q;

  // Latched at the parity strobe so the frame still runs through its stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (par_we) begin
      par_err_q <= (^shift_q) ^ bus.serial_in;
    end
  end

  assign good_stop = (bus.serial_in == STOP_BIT) && !par_err_q;
`else
  assign good_stop = (bus.serial_in == STOP_BIT);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    shift_we = 1'b0;
    load_d   = 1'b0;
    err_d    = 1'b0;
`ifdef SERIAL_PARITY_EN
    par_we   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.bit_valid && (bus.serial_in == START_BIT)) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          shift_we = 1'b1;
          cnt_en   = 1'b1;
          if (cnt_tc) begin
`ifdef SERIAL_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        if (bus.bit_valid) begin
          par_we  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bus.bit_valid) begin
          state_d = IDLE;
          if (good_stop) begin
            load_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      word_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      err_q   <= err_d;
      if (shift_we) begin
        shift_q[cnt] <= bus.serial_in;
      end
      if (load_d) begin
        word_q <= shift_q;
      end
    end
  end

  assign bus.word_out  = word_q;
  assign bus.load_en   = load_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed self-checking bench for serial_word_collector
module tb_serial_word_collector;
  import serial_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef SERIAL_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   early;
  logic bits[$];

  always #5 clk = ~clk;

  serial_word_collector_if #(.WIDTH(W)) bus ();

  serial_word_collector #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void add_frame(input logic [W-1:0] w, input logic stop, input logic par_flip);
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef SERIAL_PARITY_EN
    bits.push_back((^w) ^ par_flip);
`else
    if (par_flip) bits.push_back(1'b1);
`endif
    bits.push_back(stop);
  endfunction

  task automatic send_bit(input logic b);
    bus.serial_in = b;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  // Sends the queued bits with 'gap' idle cycles between strobes; counts pulses seen before the final bit.
  task automatic run_bits(input int gap);
    logic b;
    early = 0;
    while (bits.size() > 0) begin
      b = bits.pop_front();
      send_bit(b);
      if (bits.size() > 0) begin
        if (bus.load_en || bus.frame_err) early++;
        repeat (gap) begin
          @(negedge clk);
          if (bus.load_en || bus.frame_err) early++;
        end
      end
    end
  endtask

  initial begin
    bus.serial_in = 1'b1;
    bus.bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_word", 32'(bus.word_out), 32'h0);
    chk("rst_load", 32'(bus.load_en), 32'h0);
    chk("rst_err", 32'(bus.frame_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: good frame 5'h16
    add_frame(5'h16, 1'b1, 1'b0);
    run_bits(0);
    chk("t1_early", 32'(early), 32'd0);
    chk("t1_word", 32'(bus.word_out), 32'h16);
    chk("t1_load", 32'(bus.load_en), 32'h1);
    chk("t1_err", 32'(bus.frame_err), 32'h0);
    chk("t1_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    chk("t1_load_off", 32'(bus.load_en), 32'h0);

    // 2: bad stop bit
    add_frame(5'h16, 1'b0, 1'b0);
    run_bits(0);
    chk("t2_err", 32'(bus.frame_err), 32'h1);
    chk("t2_load", 32'(bus.load_en), 32'h0);
    chk("t2_word", 32'(bus.word_out), 32'h16);
    @(negedge clk);
    chk("t2_err_off", 32'(bus.frame_err), 32'h0);

    // 3: 5'h09 with 3 idle cycles between bits
    add_frame(5'h09, 1'b1, 1'b0);
    run_bits(3);
    chk("t3_early", 32'(early), 32'd0);
    chk("t3_word", 32'(bus.word_out), 32'h09);
    chk("t3_load", 32'(bus.load_en), 32'h1);
    @(negedge clk);
    chk("t3_load_off", 32'(bus.load_en), 32'h0);

    // 4: reset after 3 data bits, then 5'h1F
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t4_busy_mid", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    bus.serial_in = 1'b1;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    chk("t4_rst_load", 32'(bus.load_en), 32'h0);
    chk("t4_rst_err", 32'(bus.frame_err), 32'h0);
    bus.bit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_word", 32'(bus.word_out), 32'h0);
    chk("t4_rst_busy", 32'(bus.busy), 32'h0);
    add_frame(5'h1F, 1'b1, 1'b0);
    run_bits(0);
    chk("t4_early", 32'(early), 32'd0);
    chk("t4_word", 32'(bus.word_out), 32'h1F);
    chk("t4_load", 32'(bus.load_en), 32'h1);
    @(negedge clk);

    // 5: 10 idle-line strobes then back-to-back 5'h03 and 5'h1C
    for (int i = 0; i < 10; i++) bits.push_back(1'b1);
    add_frame(5'h03, 1'b1, 1'b0);
    add_frame(5'h1C, 1'b1, 1'b0);
    for (int i = 0; i < 10 + 2 * FL; i++) begin
      send_bit(bits.pop_front());
      chk($sformatf("t5_load_%0d", i), 32'(bus.load_en),
          32'((i == 10 + FL - 1) || (i == 10 + 2 * FL - 1)));
      chk($sformatf("t5_err_%0d", i), 32'(bus.frame_err), 32'h0);
      if (i == 10 + FL - 1) chk("t5_word_a", 32'(bus.word_out), 32'h03);
      if (i == 10 + 2 * FL - 1) chk("t5_word_b", 32'(bus.word_out), 32'h1C);
    end
    @(negedge clk);
    chk("t5_load_off", 32'(bus.load_en), 32'h0);

`ifdef SERIAL_PARITY_EN
    // 6: parity frames for 5'h07
    add_frame(5'h07, 1'b1, 1'b0);
    run_bits(0);
    chk("t6_good_load", 32'(bus.load_en), 32'h1);
    chk("t6_good_word", 32'(bus.word_out), 32'h07);
    @(negedge clk);
    add_frame(5'h07, 1'b1, 1'b1);
    run_bits(0);
    chk("t6_bad_err", 32'(bus.frame_err), 32'h1);
    chk("t6_bad_load", 32'(bus.load_en), 32'h0);
    @(negedge clk);
    add_frame(5'h02, 1'b0, 1'b1);
    run_bits(0);
    chk("t6_both_err", 32'(bus.frame_err), 32'h1);
    chk("t6_both_word", 32'(bus.word_out), 32'h07);
    @(negedge clk);
    chk("t6_both_err_off", 32'(bus.frame_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
